// File: rtl/adc_tx_pkg.sv
// Shared types and defaults for the ADC uplink packetizer.
// Also used by the receive-side frame checker.
package adc_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_FETCH,
        ST_LOAD,
        ST_PAYLOAD,
        ST_CRC,
        ST_DONE
    } tx_state_e;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hA5C3;
    localparam logic [15:0] DEF_CRC_POLY  = 16'h1021;
    localparam logic [15:0] DEF_CRC_INIT  = 16'hFFFF;

    localparam int LABEL_W = 5;
    localparam int DIST_W  = 10;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic        b,
        input logic [15:0] poly
    );
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial MSB-first CRC-16 register with seed reload.
// Shared between the transmit packetizer and the receive checker.
module crc16_serial
    import adc_tx_pkg::*;
#(
    parameter logic [15:0] POLY = DEF_CRC_POLY,
    parameter logic [15:0] INIT = DEF_CRC_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, bit_in, POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/adc_fifo_packetizer.sv
// Pops ADCFIFO words and serializes sync/header/payload/CRC
// packets MSB-first onto a valid/ready bit stream.
module adc_fifo_packetizer
    import adc_tx_pkg::*;
#(
    parameter int unsigned WORDS_PER_PKT = 32,
    parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter logic [15:0] CRC_POLY      = DEF_CRC_POLY,
    parameter logic [15:0] CRC_INIT      = DEF_CRC_INIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LABEL_W-1:0] label_in,
    input  logic [DIST_W-1:0]  distance_in,
    input  logic [15:0]        fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_pop,
    output logic               tx_bit,
    output logic               tx_bit_valid,
    input  logic               tx_ready,
    output logic               tx_busy,
    output logic               pkt_done,
    output logic               pkt_seq
);

    localparam logic [7:0] WORDS_LAST = 8'(WORDS_PER_PKT);

    tx_state_e          state_q;
    logic [15:0]        shift_q;
    logic [3:0]         bit_cnt_q;
    logic [7:0]         word_cnt_q;
    logic [7:0]         word_cnt_d;
    logic [LABEL_W-1:0] label_q;
    logic [DIST_W-1:0]  dist_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               seq_q;

    logic        beat;
    logic        last_bit;
    logic        crc_init;
    logic        crc_en;
    logic [15:0] crc;

    assign beat       = valid_q & tx_ready;
    assign last_bit   = beat & (bit_cnt_q == 4'hF);
    assign crc_init   = (state_q == ST_IDLE) & start;
    assign crc_en     = beat & ((state_q == ST_HDR) | (state_q == ST_PAYLOAD));
    assign word_cnt_d = word_cnt_q + 8'd1;

    crc16_serial #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (shift_q[15]),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            label_q    <= '0;
            dist_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seq_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (beat) begin
                shift_q   <= {shift_q[14:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        label_q    <= label_in;
                        dist_q     <= distance_in;
                        busy_q     <= 1'b1;
                        shift_q    <= SYNC_WORD;
                        valid_q    <= 1'b1;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        state_q    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (last_bit) begin
                        shift_q <= {seq_q, label_q, dist_q};
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (last_bit) begin
                        valid_q <= 1'b0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_q <= fifo_dout;
                    valid_q <= 1'b1;
                    state_q <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (last_bit) begin
                        word_cnt_q <= word_cnt_d;
                        if (word_cnt_d == WORDS_LAST) begin
                            // crc register lags by this beat; fold it in here
                            shift_q <= crc16_step(crc, shift_q[15], CRC_POLY);
                            state_q <= ST_CRC;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_CRC: begin
                    if (last_bit) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    seq_q   <= ~seq_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pop in FETCH so fifo_dout is ready when LOAD samples it
    assign fifo_pop     = (state_q == ST_FETCH) & ~fifo_empty;
    assign tx_bit       = shift_q[15];
    assign tx_bit_valid = valid_q;
    assign tx_busy      = busy_q;
    assign pkt_done     = done_q;
    assign pkt_seq      = seq_q;

endmodule

// File: tb/tb_adc_fifo_packetizer.sv
// Self-checking bench for adc_fifo_packetizer with a FIFO model,
// a bit collector and a polynomial-division CRC reference.
module tb_adc_fifo_packetizer;

    localparam int N = 2;
    localparam int BEATS = 16 * (3 + N);
    localparam logic [15:0] SYNC = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  label_in = '0;
    logic [9:0]  distance_in = '0;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        tx_ready = 1'b1;
    logic        fifo_pop;
    logic        tx_bit;
    logic        tx_bit_valid;
    logic        tx_busy;
    logic        pkt_done;
    logic        pkt_seq;

    always #5 clk = ~clk;

    adc_fifo_packetizer #(
        .WORDS_PER_PKT (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .label_in     (label_in),
        .distance_in  (distance_in),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_pop     (fifo_pop),
        .tx_bit       (tx_bit),
        .tx_bit_valid (tx_bit_valid),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .pkt_done     (pkt_done),
        .pkt_seq      (pkt_seq)
    );

    int errors = 0;
    int checks = 0;
    bit rx_bits[$];
    logic [15:0] fq[$];
    int done_cnt = 0;
    int pop_cnt = 0;
    bit rand_ready = 1'b0;
    bit exp_seq = 1'b0;

    always @(posedge clk) begin
        if (!rst && tx_bit_valid && tx_ready) rx_bits.push_back(tx_bit);
        if (!rst && pkt_done) done_cnt++;
        if (fifo_pop) begin
            pop_cnt++;
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL underflow: fifo_pop=1 got, 0 required (fifo empty)");
            end else begin
                fifo_dout <= fq.pop_front();
                fifo_empty <= (fq.size() == 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push(input logic [15:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic launch(input logic [4:0] l, input logic [9:0] d);
        label_in = l;
        distance_in = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 32'(n < 2000), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_bits(input int n);
        int k = 0;
        while (rx_bits.size() < n && k < 1000) begin
            tick();
            k++;
        end
        chk($sformatf("wait_bits%0d", n), 32'(k < 1000), 32'd1);
    endtask

    // Non-augmented MSB-first CRC as a remainder:
    // (INIT * x^48 + M * x^16) mod (x^16 + POLY)
    function automatic logic [15:0] ref_crc(input logic [47:0] msg);
        logic [63:0] r;
        r = {msg, 16'h0000} ^ {16'hFFFF, 48'h0};
        for (int i = 63; i >= 16; i--)
            if (r[i]) r = r ^ (64'h11021 << (i - 16));
        return r[15:0];
    endfunction

    function automatic logic [15:0] get_word(input int k);
        logic [15:0] w = '0;
        for (int b = 0; b < 16; b++)
            w = {w[14:0], (k * 16 + b < rx_bits.size()) ? rx_bits[k * 16 + b] : 1'b0};
        return w;
    endfunction

    task automatic check_pkt(input string nm, input logic [4:0] l,
                             input logic [9:0] d, input logic [15:0] w0,
                             input logic [15:0] w1, input int d0);
        logic [15:0] exp[5];
        logic [15:0] hdr;
        hdr = {exp_seq, l, d};
        exp[0] = SYNC;
        exp[1] = hdr;
        exp[2] = w0;
        exp[3] = w1;
        exp[4] = ref_crc({hdr, w0, w1});
        chk({nm, "_beats"}, 32'(rx_bits.size()), 32'(BEATS));
        for (int k = 0; k < 5; k++)
            chk($sformatf("%s_w%0d", nm, k), 32'(get_word(k)), 32'(exp[k]));
        chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        exp_seq = ~exp_seq;
        chk({nm, "_seq"}, 32'(pkt_seq), 32'(exp_seq));
        chk({nm, "_busy_low"}, 32'(tx_busy), 32'd0);
    endtask

    typedef struct {
        logic [4:0]  l;
        logic [9:0]  d;
        logic [15:0] w0;
        logic [15:0] w1;
        bit          rr;
        logic [15:0] exp_hdr;
    } vec_t;

    vec_t tv[5];

    initial begin
        int d0;
        int p0;
        int bad;
        int n;

        tv[0] = '{5'd3,  10'd100,   16'h1234, 16'hABCD, 1'b0, 16'h0C64};
        tv[1] = '{5'd3,  10'd100,   16'h1234, 16'hABCD, 1'b1, 16'h8C64};
        tv[2] = '{5'd31, 10'd1023,  16'h0000, 16'hFFFF, 1'b1, 16'h7FFF};
        tv[3] = '{5'd0,  10'd0,     16'($urandom), 16'($urandom), 1'b1, 16'h8000};
        tv[4] = '{5'd21, 10'h2AA,   16'($urandom), 16'($urandom), 1'b0, 16'h56AA};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs",
            32'({fifo_pop, tx_bit, tx_bit_valid, tx_busy, pkt_done, pkt_seq}), 32'd0);
        rst = 1'b0;
        p0 = pop_cnt;
        bad = 0;
        repeat (100) begin
            tick();
            if (tx_bit_valid || tx_busy) bad++;
        end
        chk("idle_no_pop", 32'(pop_cnt - p0), 32'd0);
        chk("idle_quiet", 32'(bad), 32'd0);

        for (int i = 0; i < 5; i++) begin
            rx_bits.delete();
            d0 = done_cnt;
            rand_ready = tv[i].rr;
            push(tv[i].w0);
            push(tv[i].w1);
            tick();
            launch(tv[i].l, tv[i].d);
            wait_done(d0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_hdr", i), 32'(get_word(1)), 32'(tv[i].exp_hdr));
            check_pkt($sformatf("vec%0d", i), tv[i].l, tv[i].d, tv[i].w0, tv[i].w1, d0);
        end
        rand_ready = 1'b0;

        rx_bits.delete();
        d0 = done_cnt;
        tick();
        launch(5'd3, 10'd100);
        wait_bits(32);
        bad = 0;
        repeat (40) begin
            tick();
            if (tx_bit_valid || fifo_pop) bad++;
        end
        chk("starve_idle", 32'(bad), 32'd0);
        chk("starve_bits", 32'(rx_bits.size()), 32'd32);
        push(16'h00FF);
        push(16'h5A5A);
        #1;
        chk("starve_pop", 32'(fifo_pop), 32'd1);
        wait_done(d0, "starve");
        check_pkt("starve", 5'd3, 10'd100, 16'h00FF, 16'h5A5A, d0);

        rx_bits.delete();
        d0 = done_cnt;
        push(16'h1111);
        push(16'h2222);
        tick();
        launch(5'd7, 10'd500);
        wait_bits(8);
        launch(5'd9, 10'd3);
        wait_bits(40);
        launch(5'd9, 10'd3);
        n = 0;
        while (!pkt_done && n < 500) begin
            tick();
            n++;
        end
        chk("busy_done_seen", 32'(n < 500), 32'd1);
        launch(5'd9, 10'd3);
        bad = 0;
        repeat (60) begin
            tick();
            if (tx_busy) bad++;
        end
        chk("busy_no_second", 32'(bad), 32'd0);
        check_pkt("busy", 5'd7, 10'd500, 16'h1111, 16'h2222, d0);

        rx_bits.delete();
        d0 = done_cnt;
        push(16'hCAFE);
        push(16'hBEEF);
        tick();
        launch(5'd1, 10'd2);
        wait_bits(36);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_outputs",
            32'({fifo_pop, tx_bit, tx_bit_valid, tx_busy, pkt_done, pkt_seq}), 32'd0);
        tick();
        rst = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        exp_seq = 1'b0;
        repeat (5) tick();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        rx_bits.delete();
        d0 = done_cnt;
        push(16'h0F0F);
        push(16'h8001);
        tick();
        launch(5'd12, 10'd345);
        wait_done(d0, "clean");
        check_pkt("clean", 5'd12, 10'd345, 16'h0F0F, 16'h8001, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
